fp_normalize_round: RTL

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

---
 rtl/fp_normalize_round.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_normalize_round                                            |
// | Brief    : normalizes a raw floating-point sum and packs it as IEEE-754  |
// |            single precision; FP_NORM_ROUND_EN selects round-to-nearest-  |
// |            even, otherwise the result is truncated.                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fp_normalize_round (
  input  logic        control,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_mant,
  output logic [31:0] out,
  output logic        exception,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sign;
  logic [8:0]  r_exp;
  logic [26:0] r_mant;

  logic        w_inc;
  logic [24:0] w_sum;
  logic [8:0]  w_exp_r;
  logic [22:0] w_frac;
  logic        w_ovf;
  logic [31:0] w_result;
  logic        w_unused;

  // r_mant layout: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
  always_comb begin
    w_inc = 1'b0;
`ifdef FP_NORM_ROUND_EN
    w_inc = r_mant[1] & (r_mant[0] | r_mant[2]);
`endif
    w_sum    = {1'b0, r_mant[25:2]} + {24'd0, w_inc};
    w_exp_r  = r_exp + {8'd0, w_sum[24]};
    w_frac   = w_sum[24] ? 23'd0 : w_sum[22:0];
    w_ovf    = (w_exp_r >= 9'd255);
    w_result = w_ovf ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_exp_r[7:0], w_frac};
  end

  // hidden bit of the rounded significand is implicit in the packed format
  assign w_unused = w_sum[23];

  always_ff @(posedge control or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sign    <= 1'b0;
      r_exp     <= 9'd0;
      r_mant    <= 27'd0;
      out       <= 32'd0;
      exception <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign   <= in_sign;
            r_exp    <= {1'b0, in_exp};
            r_mant   <= in_mant;
            in_ready <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_mant[26]) begin
            r_mant  <= {1'b0, r_mant[26:2], r_mant[1] | r_mant[0]};
            r_exp   <= r_exp + 9'd1;
            r_state <= S_ROUND;
          end else if (r_mant == 27'd0) begin
            out       <= {r_sign, 31'd0};
            exception <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_mant[25]) begin
            r_state <= S_ROUND;
          end else if (r_exp == 9'd0) begin
            // denormal results are flushed to a signed zero
            out       <= {r_sign, 31'd0};
            exception <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_mant <= {r_mant[25:0], 1'b0};
            r_exp  <= r_exp - 9'd1;
          end
        end
        S_ROUND: begin
          out       <= w_result;
          exception <= w_ovf;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
